// File: rtl/tx_huge_pages_regs_if.sv
// TRN receive-side bundle feeding the huge-page register window.
// Active-low flags, named as on the endpoint core's receive port.
interface tx_huge_pages_regs_if;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rsrc_dsc_n;
    logic        trn_rdst_rdy_n;
    logic [6:0]  trn_rbar_hit_n;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
               trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n, trn_rbar_hit_n
    );
    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
               trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n, trn_rbar_hit_n
    );
endinterface

// File: rtl/tx_huge_pages_regs.sv
// Huge-page register window: decodes posted writes from the TRN receive stream
// into per-channel page address/qword registers and a completion buffer address.
module tx_huge_pages_regs #(
    parameter int NUM_PAGES = 2,
    parameter int BAR_IDX   = 2
) (
    input  logic                        trn_clk,
    input  logic                        reset_n,
    tx_huge_pages_regs_if.slave         trn,
    input  logic [NUM_PAGES-1:0]        huge_page_free,
    output logic [NUM_PAGES-1:0][63:0]  huge_page_addr,
    output logic [NUM_PAGES-1:0][31:0]  huge_page_qwords,
    output logic [NUM_PAGES-1:0]        huge_page_status,
    output logic [63:0]                 completed_buffer_address,
    output logic [15:0]                 drop_count
);
    localparam logic [6:0] MWR32 = 7'b10_00000;
    localparam logic [6:0] MWR64 = 7'b11_00000;

    typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT, DRAIN} state_t;

    state_t      state;
    logic        is64;
    logic [9:0]  len;
    logic [6:0]  off;
    logic [63:0] data;
    logic [1:0]  cnt;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic       acc, sof, eof, dsc, hit, lo_ok;
    logic [6:0] ft;
    logic [2:0] cnt_sum;
    logic       unused_bits;

    assign acc     = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
    assign sof     = !trn.trn_rsof_n;
    assign eof     = !trn.trn_reof_n;
    assign dsc     = !trn.trn_rsrc_dsc_n;
    assign hit     = !trn.trn_rbar_hit_n[BAR_IDX];
    assign ft      = trn.trn_rd[62:56];
    // On the EOF beat a nonzero low nibble of rrem_n means only the upper DW is valid.
    assign lo_ok   = !eof || (trn.trn_rrem_n[3:0] == 4'h0);
    assign cnt_sum = {1'b0, cnt} + (lo_ok ? 3'd2 : 3'd1);
    assign unused_bits = ^{trn.trn_rrem_n[7:4], trn.trn_rbar_hit_n};

    logic [3:0]  pg;
    logic        is_addr, is_qw, is_cba, ok, do_commit;
    logic [15:0] st16;

    assign st16 = 16'(huge_page_status);

    always_comb begin
        pg      = '0;
        is_addr = 1'b0;
        is_qw   = 1'b0;
        is_cba  = 1'b0;
        ok      = 1'b0;
        if (off[6:5] == 2'b01 && !off[0]) begin
            pg      = off[4:1];
            is_addr = 1'b1;
        end else if (off[6:4] == 3'b100) begin
            pg    = off[3:0];
            is_qw = 1'b1;
        end else if (off == 7'h60) begin
            is_cba = 1'b1;
        end
        // Short payload (early EOF) fails the length check here as well.
        if ({8'b0, cnt} >= len) begin
            if (is_cba)
                ok = (len == 10'd2);
            else if ((is_addr || is_qw) && int'(pg) < NUM_PAGES)
                ok = (len == (is_addr ? 10'd2 : 10'd1)) && !st16[pg];
        end
    end

    assign do_commit = (state == COMMIT) && ok;

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                    <= IDLE;
            is64                     <= 1'b0;
            len                      <= '0;
            off                      <= '0;
            data                     <= '0;
            cnt                      <= '0;
            huge_page_addr           <= '0;
            huge_page_qwords         <= '0;
            completed_buffer_address <= '0;
            drop_count               <= '0;
        end else begin
            unique case (state)
                IDLE, COMMIT: begin
                    if (state == COMMIT) begin
                        if (ok) begin
                            if (is_cba) completed_buffer_address <= data;
                            for (int k = 0; k < NUM_PAGES; k++) begin
                                if (pg == k[3:0] && is_addr) huge_page_addr[k]   <= data;
                                if (pg == k[3:0] && is_qw)   huge_page_qwords[k] <= data[31:0];
                            end
                        end else if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                    // COMMIT also behaves as IDLE so a back-to-back SOF is not lost.
                    state <= IDLE;
                    if (acc && sof && hit) begin
                        is64 <= (ft == MWR64);
                        len  <= trn.trn_rd[41:32];
                        cnt  <= '0;
                        data <= '0;
                        if (ft == MWR32 || ft == MWR64) state <= HDR;
                        else if (!eof)                  state <= DRAIN;
                    end
                end
                HDR: if (acc) begin
                    if (dsc) begin
                        state <= IDLE;
                    end else begin
                        if (is64) begin
                            off <= trn.trn_rd[8:2];
                        end else begin
                            off <= trn.trn_rd[40:34];
                            if (lo_ok) begin
                                data[31:0] <= bswap(trn.trn_rd[31:0]);
                                cnt        <= 2'd1;
                            end
                        end
                        state <= eof ? COMMIT : DATA;
                    end
                end
                DATA: if (acc) begin
                    if (dsc) begin
                        state <= IDLE;
                    end else begin
                        case (cnt)
                            2'd0: begin
                                data[31:0] <= bswap(trn.trn_rd[63:32]);
                                if (lo_ok) data[63:32] <= bswap(trn.trn_rd[31:0]);
                            end
                            2'd1:    data[63:32] <= bswap(trn.trn_rd[63:32]);
                            default: ;
                        endcase
                        cnt <= cnt_sum[2] ? 2'd3 : cnt_sum[1:0];
                        if (eof) state <= COMMIT;
                    end
                end
                DRAIN: if (acc && (eof || dsc)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // An unlock committing on the same edge as a free keeps the page locked.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            huge_page_status <= '0;
        end else begin
            for (int k = 0; k < NUM_PAGES; k++) begin
                if (do_commit && is_qw && pg == k[3:0]) huge_page_status[k] <= 1'b1;
                else if (huge_page_free[k])             huge_page_status[k] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_huge_pages_regs.sv
// Directed bench: tasks push expected output snapshots, a negedge monitor pops
// and compares whenever the DUT outputs change, including the change cycle.
module tb_tx_huge_pages_regs;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_huge_pages_regs_if bus();

    logic [NP-1:0]       free;
    logic [NP-1:0][63:0] addr;
    logic [NP-1:0][31:0] qw;
    logic [NP-1:0]       st;
    logic [63:0]         cba;
    logic [15:0]         drop;

    tx_huge_pages_regs #(.NUM_PAGES(NP), .BAR_IDX(2)) dut (
        .trn_clk                  (clk),
        .reset_n                  (rst_n),
        .trn                      (bus.slave),
        .huge_page_free           (free),
        .huge_page_addr           (addr),
        .huge_page_qwords         (qw),
        .huge_page_status         (st),
        .completed_buffer_address (cba),
        .drop_count               (drop)
    );

    typedef struct packed {
        logic [NP-1:0][63:0] addr;
        logic [NP-1:0][31:0] qw;
        logic [NP-1:0]       st;
        logic [63:0]         cba;
        logic [15:0]         drop;
    } snap_t;

    typedef struct packed {
        snap_t       s;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    snap_t       m, prev, cur;
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    bit          mon_en = 1'b0;

    assign cur = {addr, qw, st, cba, drop};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && cur !== prev) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_change @%0d: got %h, nothing pending", cyc, cur);
            end else begin
                e = q.pop_front();
                if (cur !== e.s || cyc != e.cyc) begin
                    nerr++;
                    $display("FAIL vec%0d: got %h @%0d, want %h @%0d", nvec, cur, cyc, e.s, e.cyc);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input int d);
        exp_t x;
        x.s   = m;
        x.cyc = cyc + d;
        q.push_back(x);
    endtask

    task automatic idle();
        bus.trn_rd         = '0;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.trn_rsrc_dsc_n = 1'b1;
        bus.trn_rdst_rdy_n = 1'b0;
        bus.trn_rbar_hit_n = 7'h7F;
    endtask

    task automatic beat(input logic [63:0] rd, input bit sof, input bit eof,
                        input bit dsc, input bit hit);
        @(posedge clk); #1;
        bus.trn_rd         = rd;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rsof_n     = !sof;
        bus.trn_reof_n     = !eof;
        bus.trn_rsrc_dsc_n = !dsc;
        bus.trn_rsrc_rdy_n = 1'b0;
        bus.trn_rbar_hit_n = hit ? 7'h7B : 7'h7F;
    endtask

    // Returns one cycle after the EOF beat is accepted; a commit lands on the next edge.
    task automatic end_tlp();
        @(posedge clk); #1;
        idle();
    endtask

    function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len);
        return {1'b0, ft, 14'h0, len, 32'h0000_00FF};
    endfunction

    task automatic mwr64(input logic [6:0] off, input logic [9:0] len,
                         input logic [31:0] d0, input logic [31:0] d1, input bit dsc);
        beat(hdr(7'h60, len), 1, 0, 0, 1);
        beat({32'h0, 23'h0, off, 2'b00}, 0, 0, 0, 1);
        beat({d0, d1}, 0, 1, dsc, 1);
        end_tlp();
    endtask

    task automatic mwr32(input logic [6:0] off, input logic [9:0] len,
                         input logic [31:0] d0, input bit hit);
        beat(hdr(7'h40, len), 1, 0, 0, hit);
        beat({23'h0, off, 2'b00, d0}, 0, 1, 0, hit);
        end_tlp();
    endtask

    initial begin
        idle();
        free = '0;
        m    = '0;
        #12;
        nvec++;
        if (cur !== snap_t'(0)) begin
            nerr++;
            $display("FAIL reset_state: got %h, want all zero", cur);
        end
        prev   = cur;
        mon_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // page-1 address, byte-reversed 64-bit payload
        mwr64(7'h22, 10'd2, 32'h4433_2211, 32'h8877_6655, 0);
        m.addr[1] = 64'h5566_7788_1122_3344; push(1);

        // page-0 qwords unlock
        mwr32(7'h40, 10'd1, 32'h0001_0000, 1);
        m.qw[0] = 32'h0000_0100; m.st[0] = 1'b1; push(1);

        // lone free clears status
        @(posedge clk); #1 free = 2'b01;
        m.st[0] = 1'b0; push(1);
        @(posedge clk); #1 free = 2'b00;

        // free on the commit edge: set wins; free one cycle later clears
        mwr32(7'h40, 10'd1, 32'h0002_0000, 1);
        free = 2'b01;
        m.qw[0] = 32'h0000_0200; m.st[0] = 1'b1; push(1);
        @(posedge clk); #1;
        m.st[0] = 1'b0; push(1);
        @(posedge clk); #1 free = 2'b00;

        // lock page 1, then two rejected writes
        mwr32(7'h41, 10'd1, 32'h0700_0000, 1);
        m.qw[1] = 32'h0000_0007; m.st[1] = 1'b1; push(1);
        mwr64(7'h22, 10'd2, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 0);
        m.drop = 16'd1; push(1);
        mwr32(7'h60, 10'd1, 32'hCCCC_CCCC, 1);
        m.drop = 16'd2; push(1);

        // no-effect traffic: BAR miss, non-write drained, discontinued write
        mwr32(7'h40, 10'd1, 32'h0009_0000, 0);
        beat(hdr(7'h00, 10'd1), 1, 0, 0, 1);
        beat({23'h0, 7'h40, 2'b00, 32'h0005_0000}, 0, 1, 0, 1);
        end_tlp();
        mwr64(7'h60, 10'd2, 32'h1111_1111, 32'h2222_2222, 1);

        // next TLP after the abort decodes normally
        mwr64(7'h60, 10'd2, 32'hEFBE_ADDE, 32'h0DF0_ADBA, 0);
        m.cba = 64'hBAAD_F00D_DEAD_BEEF; push(1);

        // early EOF on the MWr64 address beat
        beat(hdr(7'h60, 10'd2), 1, 0, 0, 1);
        beat({32'h0, 23'h0, 7'h60, 2'b00}, 0, 1, 0, 1);
        end_tlp();
        m.drop = 16'd3; push(1);

        // unmapped offset, then a channel beyond NUM_PAGES
        mwr32(7'h50, 10'd1, 32'h0100_0000, 1);
        m.drop = 16'd4; push(1);
        mwr32(7'h43, 10'd1, 32'h0100_0000, 1);
        m.drop = 16'd5; push(1);

        // lock both channels, then free both on one edge
        mwr32(7'h40, 10'd1, 32'h0000_0300, 1);
        m.qw[0] = 32'h0003_0000; m.st[0] = 1'b1; push(1);
        @(posedge clk); #1 free = 2'b11;
        m.st = 2'b00; push(1);
        @(posedge clk); #1 free = 2'b00;

        // reset in the middle of a payload
        beat(hdr(7'h60, 10'd2), 1, 0, 0, 1);
        beat({32'h0, 23'h0, 7'h20, 2'b00}, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle();
        m = '0; push(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        mwr64(7'h20, 10'd2, 32'h0403_0201, 32'h0807_0605, 0);
        m.addr[0] = 64'h0506_0708_0102_0304; push(1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL pending_at_end: got %0d outstanding, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
